// File: rtl/bpi_cmd_seq.sv
// BPI command sequencer: pops FIFO commands, drives the control FSM qualifiers, owns the
// transfer word counter and the no-progress watchdog. Define BPI_CMD_STATS_EN for CMD_CNT/RD_WORDS.
module bpi_cmd_seq #(
  parameter int               CNT_W   = 12,
  parameter int               TMO_W   = 24,
  parameter logic [TMO_W-1:0] TMO_MAX = 24'hFFFFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic [15:0] CMD_DATA,
  input  logic        CMD_VLD,
  output logic        CMD_RE,
  output logic        FSM_WRITE_N,
  output logic        FSM_READ_N,
  output logic        FSM_OTHER,
  output logic        FSM_READ_1,
  output logic        FSM_TWO_CYCLE,
  output logic        FSM_NOOP,
  output logic        FSM_TERM_CNT,
  input  logic        FSM_DECR,
  input  logic        FSM_NEXT,
  input  logic        FSM_SEQ_DONE,
  input  logic        CLR_ERR,
  output logic        SEQ_BUSY,
  output logic [4:0]  CUR_OP,
  output logic        ILL_OP,
  output logic        TMO_ERR,
  output logic [15:0] CMD_CNT,
  output logic [15:0] RD_WORDS
);

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_OTHER = 5'h01;
  localparam logic [4:0] OP_TWO   = 5'h02;
  localparam logic [4:0] OP_RD1   = 5'h03;
  localparam logic [4:0] OP_READ  = 5'h04;
  localparam logic [4:0] OP_WRITE = 5'h05;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_ACTIVE = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  typedef struct packed {
    logic write_n;
    logic read_n;
    logic other;
    logic read_1;
    logic two_cycle;
  } qual_t;

  localparam qual_t QUAL_NONE = '0;

  state_t           r_state;
  qual_t            r_qual;
  logic             r_cmd_re;
  logic             r_noop;
  logic             r_busy;
  logic [4:0]       r_cur_op;
  logic             r_ill_op;
  logic             r_tmo_err;
  logic [CNT_W-1:0] r_cnt;
  logic [TMO_W-1:0] r_wd;

  logic [CNT_W-1:0] w_cnt_load;
  logic [TMO_W-1:0] w_wd_inc;

  assign w_cnt_load = CNT_W'(CMD_DATA[15:5]) + CNT_W'(1);
  assign w_wd_inc   = r_wd + TMO_W'(1);

  // Handshake: CMD_VLD means CMD_DATA holds the FIFO head. CMD_RE is a one-cycle pop strobe
  // raised in FETCH; the head is captured on the same edge that pops it, so CMD_VLD is never
  // looked at again for that command.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_qual    <= QUAL_NONE;
      r_cmd_re  <= 1'b0;
      r_noop    <= 1'b0;
      r_busy    <= 1'b0;
      r_cur_op  <= '0;
      r_ill_op  <= 1'b0;
      r_tmo_err <= 1'b0;
      r_cnt     <= '0;
      r_wd      <= '0;
    end else begin
      r_cmd_re <= 1'b0;
      if (CLR_ERR) begin
        r_ill_op  <= 1'b0;
        r_tmo_err <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (ENABLE && CMD_VLD) begin
            r_state  <= S_FETCH;
            r_busy   <= 1'b1;
            r_cmd_re <= 1'b1;
          end
        end
        S_FETCH: begin
          r_cur_op <= CMD_DATA[4:0];
          r_cnt    <= w_cnt_load;
          r_state  <= S_ISSUE;
        end
        S_ISSUE: begin
          r_wd    <= '0;
          r_state <= S_ACTIVE;
          case (r_cur_op)
            OP_OTHER: r_qual <= '{write_n: 1'b0, read_n: 1'b0, other: 1'b1, read_1: 1'b0, two_cycle: 1'b0};
            OP_TWO:   r_qual <= '{write_n: 1'b0, read_n: 1'b0, other: 1'b1, read_1: 1'b0, two_cycle: 1'b1};
            OP_RD1:   r_qual <= '{write_n: 1'b0, read_n: 1'b0, other: 1'b1, read_1: 1'b1, two_cycle: 1'b0};
            OP_READ:  r_qual <= '{write_n: 1'b0, read_n: 1'b1, other: 1'b0, read_1: 1'b0, two_cycle: 1'b0};
            OP_WRITE: r_qual <= '{write_n: 1'b1, read_n: 1'b0, other: 1'b0, read_1: 1'b0, two_cycle: 1'b0};
            OP_NOP: begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
            default: begin
              r_ill_op <= 1'b1;
              r_state  <= S_IDLE;
              r_busy   <= 1'b0;
            end
          endcase
        end
        S_ACTIVE: begin
          if (FSM_DECR && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
          // Sequence completion wins over a watchdog expiry landing in the same cycle.
          if (FSM_SEQ_DONE) begin
            r_qual  <= QUAL_NONE;
            r_noop  <= 1'b1;
            r_state <= S_DONE;
          end else if (FSM_DECR || FSM_NEXT) begin
            r_wd <= '0;
          end else if (w_wd_inc == TMO_MAX) begin
            r_wd      <= w_wd_inc;
            r_qual    <= QUAL_NONE;
            r_tmo_err <= 1'b1;
            r_state   <= S_ERR;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        S_DONE: begin
          if (!FSM_SEQ_DONE) begin
            r_noop  <= 1'b0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_ERR: begin
          if (CLR_ERR) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_qual  <= QUAL_NONE;
          r_noop  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Qualifiers are all-zero outside READ_N/WRITE_N, which masks the unused counter of other ops.
  assign FSM_TERM_CNT  = (r_cnt == '0) && (r_qual.write_n || r_qual.read_n);

  assign CMD_RE        = r_cmd_re;
  assign FSM_WRITE_N   = r_qual.write_n;
  assign FSM_READ_N    = r_qual.read_n;
  assign FSM_OTHER     = r_qual.other;
  assign FSM_READ_1    = r_qual.read_1;
  assign FSM_TWO_CYCLE = r_qual.two_cycle;
  assign FSM_NOOP      = r_noop;
  assign SEQ_BUSY      = r_busy;
  assign CUR_OP        = r_cur_op;
  assign ILL_OP        = r_ill_op;
  assign TMO_ERR       = r_tmo_err;

`ifdef BPI_CMD_STATS_EN
  logic [15:0] r_cmd_cnt;
  logic [15:0] r_rd_words;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cmd_cnt  <= '0;
      r_rd_words <= '0;
    end else if (CLR_ERR) begin
      r_cmd_cnt  <= '0;
      r_rd_words <= '0;
    end else begin
      if ((r_state == S_DONE) && !FSM_SEQ_DONE) begin
        r_cmd_cnt <= r_cmd_cnt + 16'd1;
      end
      if (FSM_DECR && r_qual.read_n) begin
        r_rd_words <= r_rd_words + 16'd1;
      end
    end
  end

  assign CMD_CNT  = r_cmd_cnt;
  assign RD_WORDS = r_rd_words;
`else
  assign CMD_CNT  = '0;
  assign RD_WORDS = '0;
`endif

endmodule

// File: tb/tb_bpi_cmd_seq.sv
// Bench for bpi_cmd_seq: FIFO and control-FSM stand-ins, a table-driven opcode model feeding
// an expected queue, a monitor that scores each popped command, and a TERM_CNT tracker.
`timescale 1ns/1ps
module tb_bpi_cmd_seq;

  localparam int W = 13;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENABLE = 1'b0;
  logic [15:0] CMD_DATA = 16'd0;
  logic        CMD_VLD = 1'b0;
  logic        FSM_DECR = 1'b0;
  logic        FSM_NEXT = 1'b0;
  logic        FSM_SEQ_DONE = 1'b0;
  logic        CLR_ERR = 1'b0;
  logic        CMD_RE, FSM_WRITE_N, FSM_READ_N, FSM_OTHER, FSM_READ_1, FSM_TWO_CYCLE;
  logic        FSM_NOOP, FSM_TERM_CNT, SEQ_BUSY, ILL_OP, TMO_ERR;
  logic [4:0]  CUR_OP;
  logic [15:0] CMD_CNT, RD_WORDS;

  bpi_cmd_seq #(.CNT_W(12), .TMO_W(24), .TMO_MAX(24'd16)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .CMD_DATA(CMD_DATA), .CMD_VLD(CMD_VLD),
    .CMD_RE(CMD_RE), .FSM_WRITE_N(FSM_WRITE_N), .FSM_READ_N(FSM_READ_N),
    .FSM_OTHER(FSM_OTHER), .FSM_READ_1(FSM_READ_1), .FSM_TWO_CYCLE(FSM_TWO_CYCLE),
    .FSM_NOOP(FSM_NOOP), .FSM_TERM_CNT(FSM_TERM_CNT), .FSM_DECR(FSM_DECR),
    .FSM_NEXT(FSM_NEXT), .FSM_SEQ_DONE(FSM_SEQ_DONE), .CLR_ERR(CLR_ERR),
    .SEQ_BUSY(SEQ_BUSY), .CUR_OP(CUR_OP), .ILL_OP(ILL_OP), .TMO_ERR(TMO_ERR),
    .CMD_CNT(CMD_CNT), .RD_WORDS(RD_WORDS)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            failures = 0;
  logic [W-1:0]  exp_q[$];
  logic [15:0]   fifo_q[$];
  bit            active_flag = 1'b0;
  bit            cur_rw = 1'b0;
  int            cur_words = 0;
  int            dec_count = 0;
  logic [15:0]   exp_cmd_cnt = 16'd0;
  logic [15:0]   exp_rd_words = 16'd0;

  logic [4:0]  quals;
  logic [15:0] out_vec;
  assign quals   = {FSM_WRITE_N, FSM_READ_N, FSM_OTHER, FSM_READ_1, FSM_TWO_CYCLE};
  assign out_vec = {CMD_RE, quals, FSM_NOOP, FSM_TERM_CNT, SEQ_BUSY, ILL_OP, TMO_ERR, CUR_OP};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Qualifier vector {WRITE_N, READ_N, OTHER, READ_1, TWO_CYCLE} per opcode.
  function automatic logic [4:0] qual_of(input logic [4:0] op);
    logic [4:0] tab [0:5];
    tab = '{5'b00000, 5'b00100, 5'b00101, 5'b00110, 5'b01000, 5'b10000};
    if (op > 5'd5) return 5'b00000;
    return tab[op[2:0]];
  endfunction

  // {ILL_OP, SEQ_BUSY, NOOP, qualifiers, CUR_OP} one cycle after the issue step.
  function automatic logic [W-1:0] model_rec(input logic [4:0] op);
    bit ill;
    bit busy;
    ill  = (op > 5'd5);
    busy = (op >= 5'd1) && (op <= 5'd5);
    return {ill, busy, 1'b0, qual_of(op), op};
  endfunction

  function automatic logic [15:0] stat_exp(input logic [15:0] v);
`ifdef BPI_CMD_STATS_EN
    return v;
`else
    return 16'd0 & v;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fifo_refresh();
    CMD_VLD  = (fifo_q.size() != 0);
    CMD_DATA = CMD_VLD ? fifo_q[0] : 16'($urandom);
  endtask

  task automatic pulse_clr();
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    exp_cmd_cnt  = 16'd0;
    exp_rd_words = 16'd0;
  endtask

  task automatic start_cmd(input logic [15:0] word, input int hold, output bit ok);
    int n;
    logic [4:0] op;
    op        = word[4:0];
    cur_words = int'(word[15:5]) + 1;
    cur_rw    = (op == 5'd4) || (op == 5'd5);
    dec_count = 0;
    exp_q.push_back(model_rec(op));
    if (hold > 0) ENABLE = 1'b0;
    fifo_q.push_back(word);
    fifo_refresh();
    if (hold > 0) begin
      repeat (hold) begin
        tick();
        check("enable_hold", 32'({CMD_RE, SEQ_BUSY}), 32'd0);
      end
      ENABLE = 1'b1;
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (!CMD_RE && n < 20);
    check("fetch_latency", 32'(n), 32'd1);
    ok = CMD_RE;
    if (ok) begin
      tick();
      tick();
    end
  endtask

  task automatic run_cmd(input logic [15:0] word, input bit stall, input bit extra, input int hold);
    bit ok;
    logic [4:0] op;
    op = word[4:0];
    start_cmd(word, hold, ok);
    if (!ok) return;
    if (!((op >= 5'd1) && (op <= 5'd5))) begin
      check("dropped_idle", 32'(SEQ_BUSY), 32'd0);
      if (op > 5'd5) begin
        pulse_clr();
        check("ill_cleared", 32'(ILL_OP), 32'd0);
      end
      return;
    end
    active_flag = 1'b1;
    if (stall) begin
      repeat (15) tick();
      check("tmo_not_yet", 32'({TMO_ERR, SEQ_BUSY}), 32'b01);
      tick();
      active_flag = 1'b0;
      check("tmo_err", 32'({TMO_ERR, SEQ_BUSY, FSM_NOOP, quals}), 32'b11000000);
      repeat ($urandom_range(0, 3)) tick();
      check("err_hold", 32'({TMO_ERR, SEQ_BUSY}), 32'b11);
      pulse_clr();
      check("err_release", 32'({TMO_ERR, SEQ_BUSY, ILL_OP}), 32'd0);
      return;
    end
    if (cur_rw) begin
      for (int i = 0; i < cur_words + int'(extra); i++) begin
        repeat ($urandom_range(0, 3)) begin
          tick();
          ENABLE = ($urandom_range(0, 3) != 0);
        end
        FSM_DECR = 1'b1;
        FSM_NEXT = 1'($urandom_range(0, 1));
        tick();
        FSM_DECR = 1'b0;
        FSM_NEXT = 1'b0;
        dec_count++;
        if (op == 5'd4) exp_rd_words++;
      end
    end else begin
      repeat ($urandom_range(1, 6)) begin
        tick();
        FSM_NEXT = 1'($urandom_range(0, 1));
        ENABLE   = ($urandom_range(0, 3) != 0);
      end
      FSM_NEXT = 1'b0;
    end
    tick();
    FSM_SEQ_DONE = 1'b1;
    tick();
    active_flag = 1'b0;
    check("done_state", 32'({FSM_NOOP, SEQ_BUSY, quals}), 32'b1100000);
    repeat ($urandom_range(0, 2)) begin
      tick();
      check("noop_hold", 32'({FSM_NOOP, SEQ_BUSY}), 32'b11);
    end
    FSM_SEQ_DONE = 1'b0;
    ENABLE = 1'b1;
    tick();
    check("back_idle", 32'({FSM_NOOP, SEQ_BUSY}), 32'd0);
    exp_cmd_cnt++;
    check("cmd_cnt", 32'(CMD_CNT), 32'(stat_exp(exp_cmd_cnt)));
    check("rd_words", 32'(RD_WORDS), 32'(stat_exp(exp_rd_words)));
  endtask

  // ---------------- FIFO stand-in ----------------
  initial begin : fifo_model
    forever begin
      @(negedge CLK);
      if (!RST && CMD_RE) begin
        @(posedge CLK);
        #1;
        check("fifo_nonempty_at_pop", 32'(fifo_q.size() != 0), 32'd1);
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_refresh();
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [W-1:0] exp_rec;
    forever begin
      @(negedge CLK);
      if (!RST && CMD_RE) begin
        check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_rec = exp_q.pop_front();
          @(posedge CLK);
          @(posedge CLK);
          @(negedge CLK);
          check("cmd_result", 32'({ILL_OP, SEQ_BUSY, FSM_NOOP, quals, CUR_OP}), 32'(exp_rec));
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      check("term_cnt", 32'(FSM_TERM_CNT), 32'(active_flag && cur_rw && (dec_count >= cur_words)));
    end
  end

  initial begin : global_timeout
    #800000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "bench timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    bit ok;
    logic [4:0]  op;
    logic [10:0] cnt;
    int sel;
    RST = 1'b1;
    fifo_refresh();
    repeat (3) tick();
    check("reset_state", 32'(out_vec), 32'd0);
    check("reset_cmd_cnt", 32'(CMD_CNT), 32'd0);
    check("reset_rd_words", 32'(RD_WORDS), 32'd0);
    RST = 1'b0;
    ENABLE = 1'b1;
    tick();

    run_cmd(16'h0065, 1'b0, 1'b0, 0);
    run_cmd(16'h0023, 1'b0, 1'b0, 0);
    run_cmd(16'h001F, 1'b0, 1'b0, 0);
    run_cmd(16'h0000, 1'b0, 1'b0, 0);
    run_cmd(16'h0045, 1'b1, 1'b0, 0);
    run_cmd(16'h0002, 1'b0, 1'b0, 4);
    run_cmd(16'h0001, 1'b0, 1'b0, 0);

    start_cmd(16'h00E4, 0, ok);
    if (ok) begin
      active_flag = 1'b1;
      repeat (2) begin
        FSM_DECR = 1'b1;
        tick();
        FSM_DECR = 1'b0;
        dec_count++;
        exp_rd_words++;
        tick();
      end
      #2;
      RST = 1'b1;
      active_flag = 1'b0;
      exp_cmd_cnt = 16'd0;
      exp_rd_words = 16'd0;
      #1;
      check("reset_mid_op", 32'(out_vec), 32'd0);
      check("reset_mid_cmd_cnt", 32'(CMD_CNT), 32'd0);
      check("reset_mid_rd_words", 32'(RD_WORDS), 32'd0);
      tick();
      tick();
      RST = 1'b0;
    end
    run_cmd(16'h0044, 1'b0, 1'b1, 0);

    pulse_clr();
    run_cmd(16'h0024, 1'b0, 1'b0, 0);
    run_cmd(16'h0001, 1'b0, 1'b0, 0);
    check("stats_two_cmds", 32'({CMD_CNT, RD_WORDS}), 32'({stat_exp(16'd2), stat_exp(16'd2)}));

    run_cmd(16'hFFE5, 1'b0, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 11);
      if (sel <= 5)      op = 5'(sel);
      else if (sel <= 7) op = 5'($urandom_range(6, 31));
      else               op = ($urandom_range(0, 1) != 0) ? 5'd4 : 5'd5;
      cnt = 11'($urandom_range(0, 6));
      run_cmd({cnt, op}, ((op >= 5'd1) && (op <= 5'd5) && ($urandom_range(0, 9) == 0)),
              1'($urandom_range(0, 3) == 0), (($urandom_range(0, 7) == 0) ? 2 : 0));
    end

    repeat (4) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("fifo_drained", 32'(fifo_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
